// File: rtl/uart_rx_fifo.sv
// UART receiver with first-word-fall-through receive FIFO and sticky overrun / pulsed error flags.
// Optional parity bit checking is built when the macro UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                          iCE_CLK,
    input  logic                          rst_n,
    input  logic                          RX,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rx_byte,
    output logic                          rx_valid,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          parity_err
);

    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int BW   = $clog2(CPB);
    localparam int NW   = $clog2(DATA_BITS);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t               state_r, state_nxt_s;
    logic                 rx_meta_r, rx_sync_r, rx_prev_r;
    logic [BW-1:0]        baud_r, baud_nxt_s;
    logic [NW-1:0]        bit_r, bit_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic                 push_s, frame_err_s, parity_err_s;
    logic                 push_r, frame_err_r, parity_err_r;
    logic [DATA_BITS-1:0] push_data_r;
    logic                 baud_last_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_r, par_bit_nxt_s;

    function automatic logic parity_calc(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    // Two-flop synchroniser plus one history flop for start-edge detection
    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            {rx_meta_r, rx_sync_r, rx_prev_r} <= 3'b111;
        end else begin
            {rx_meta_r, rx_sync_r, rx_prev_r} <= {RX, rx_meta_r, rx_sync_r};
        end
    end

    assign baud_last_s = (baud_r == BW'(CPB - 1));

    // Frame FSM next-state, bit/baud counting and end-of-frame verdict
    always_comb begin
        state_nxt_s  = state_r;
        baud_nxt_s   = baud_r + 1'b1;
        bit_nxt_s    = bit_r;
        shift_nxt_s  = shift_r;
        push_s       = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt_s = par_bit_r;
`endif
        case (state_r)
            IDLE: begin
                baud_nxt_s = '0;
                if (rx_prev_r && !rx_sync_r) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (baud_r == BW'(HALF)) begin
                    baud_nxt_s  = '0;
                    bit_nxt_s   = '0;
                    state_nxt_s = rx_sync_r ? IDLE : DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (baud_last_s) begin
                    baud_nxt_s  = '0;
                    shift_nxt_s = {rx_sync_r, shift_r[DATA_BITS-1:1]};
                    bit_nxt_s   = bit_r + 1'b1;
                    if (bit_r == NW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = PARITY;
`else
                        state_nxt_s = STOP;
`endif
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_last_s) begin
                    baud_nxt_s    = '0;
                    par_bit_nxt_s = rx_sync_r;
                    state_nxt_s   = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (baud_last_s) begin
                    baud_nxt_s  = '0;
                    state_nxt_s = IDLE;
                    if (!rx_sync_r) begin
                        frame_err_s = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (parity_calc(shift_r) ^ par_bit_r ^ PARITY_ODD) begin
                        parity_err_s = 1'b1;
`endif
                    end else begin
                        push_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                baud_nxt_s  = '0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Frame FSM state and registered push request / error pulses
    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            baud_r       <= '0;
            bit_r        <= '0;
            shift_r      <= '0;
            push_r       <= 1'b0;
            push_data_r  <= '0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_r    <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            baud_r       <= baud_nxt_s;
            bit_r        <= bit_nxt_s;
            shift_r      <= shift_nxt_s;
            push_r       <= push_s;
            push_data_r  <= shift_r;
            frame_err_r  <= frame_err_s;
            parity_err_r <= parity_err_s;
`ifdef UART_RX_PARITY_EN
            par_bit_r    <= par_bit_nxt_s;
`endif
        end
    end

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [CW-1:0]        count_r, count_nxt_s;
    logic [DATA_BITS-1:0] rx_byte_r, head_nxt_s;
    logic                 rx_valid_r, fifo_full_r, overrun_r;
    logic                 pop_s, wr_s, drop_s;

    // FIFO accounting; the head word is precomputed so rx_byte comes straight from a flop
    always_comb begin
        pop_s     = rd_en && rx_valid_r;
        wr_s      = push_r && (!fifo_full_r || pop_s);
        drop_s    = push_r && fifo_full_r && !pop_s;
        rd_next_s = rd_ptr_r + 1'b1;
        case ({wr_s, pop_s})
            2'b10:   count_nxt_s = count_r + 1'b1;
            2'b01:   count_nxt_s = count_r - 1'b1;
            default: count_nxt_s = count_r;
        endcase
        if (wr_s && ((count_r == CW'(0)) || (pop_s && (count_r == CW'(1))))) begin
            head_nxt_s = push_data_r;
        end else if (pop_s && (count_r > CW'(1))) begin
            head_nxt_s = mem_r[rd_next_s];
        end else if (pop_s) begin
            head_nxt_s = '0;
        end else begin
            head_nxt_s = rx_byte_r;
        end
    end

    // FIFO storage array
    always_ff @(posedge iCE_CLK) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= push_data_r;
        end
    end

    // FIFO pointers, count, registered status and sticky overrun
    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            rx_byte_r   <= '0;
            rx_valid_r  <= 1'b0;
            fifo_full_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_next_s;
            end
            count_r     <= count_nxt_s;
            rx_byte_r   <= head_nxt_s;
            rx_valid_r  <= (count_nxt_s != CW'(0));
            fifo_full_r <= (count_nxt_s == CW'(FIFO_DEPTH));
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (clr_err) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign rx_byte    = rx_byte_r;
    assign rx_valid   = rx_valid_r;
    assign fifo_full  = fifo_full_r;
    assign fifo_count = count_r;
    assign overrun    = overrun_r;
    assign frame_err  = frame_err_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames push expected words, a negedge monitor checks pops.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 173;
`else
    localparam int LAT = 157;
`endif

    logic       clk = 1'b0;
    logic       rst_n, rx, rd_en, clr_err;
    logic [7:0] rx_byte;
    logic       rx_valid, fifo_full, overrun, frame_err, parity_err;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int rise_cyc  = -1;
    int fe_pulses = 0, fe_cycles = 0, pe_pulses = 0;
    logic valid_prev = 1'b0, fe_prev = 1'b0, pe_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_fifo #(
        .CLK_HZ(16000000), .BAUD(1000000), .DATA_BITS(8), .FIFO_DEPTH(4)
    ) dut (
        .iCE_CLK(clk), .rst_n(rst_n), .RX(rx), .rd_en(rd_en), .clr_err(clr_err),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .fifo_full(fifo_full),
        .fifo_count(fifo_count), .overrun(overrun), .frame_err(frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares on every accepted read, tracks flag pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rd_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no word", rx_byte);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("pop_data", int'(rx_byte), int'(exp_w));
                end
            end
            if (rx_valid && !valid_prev && rise_cyc < 0) rise_cyc = cyc;
            if (frame_err) fe_cycles++;
            if (frame_err && !fe_prev) fe_pulses++;
            if (parity_err && !pe_prev) pe_pulses++;
            valid_prev = rx_valid;
            fe_prev    = frame_err;
            pe_prev    = parity_err;
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int nbits);
        @(posedge clk);
        #1 rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            #1 rx = d[i];
            repeat (CPB) @(posedge clk);
        end
        if (nbits == 8) begin
`ifdef UART_RX_PARITY_EN
            #1 rx = (^d) ^ par_flip;
            repeat (CPB) @(posedge clk);
`endif
            #1 rx = stop_bit;
            repeat (CPB) @(posedge clk);
        end
        #1 rx = 1'b1;
    endtask

    task automatic read_words(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!rx_valid && t < 400) begin
                @(posedge clk);
                #1 t++;
            end
            check("read_valid", int'(rx_valid), 1);
            rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, fc0, pe0;
        rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_status", int'({rx_valid, fifo_full, overrun, frame_err, parity_err}), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_byte", int'(rx_byte), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 1: single word, latency from start edge, single pop empties
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 8);
        check("t1_latency", rise_cyc - start_cyc, LAT);
        check("t1_count", int'(fifo_count), 1);
        read_words(1);
        check("t1_empty", int'(rx_valid), 0);

        // 2: five words, no reads -> full, overrun, first four kept
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 8);
        end
        check("t2_count", int'(fifo_count), 4);
        check("t2_full", int'(fifo_full), 1);
        check("t2_overrun", int'(overrun), 1);
        read_words(4);
        check("t2_drained", int'(fifo_count), 0);
        check("t2_ovr_sticky", int'(overrun), 1);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        check("t2_ovr_clear", int'(overrun), 0);

        // 3: 4-clock glitch is ignored, receiver still takes the next frame
        fe0 = fe_pulses; pe0 = pe_pulses;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("t3_count", int'(fifo_count), 0);
        check("t3_flags", (fe_pulses - fe0) + (pe_pulses - pe0), 0);
        exp_q.push_back(8'h66);
        send_frame(8'h66, 1'b1, 8);
        read_words(1);

        // 4: bad stop bit -> one-cycle frame_err, nothing stored
        fe0 = fe_pulses; fc0 = fe_cycles;
        send_frame(8'h3C, 1'b0, 8);
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("t4_fe_pulse", fe_pulses - fe0, 1);
        check("t4_fe_width", fe_cycles - fc0, 1);
        check("t4_count", int'(fifo_count), 0);

        // Break: long low line gives exactly one frame_err
        fe0 = fe_pulses;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (25 * CPB) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("brk_fe_once", fe_pulses - fe0, 1);
        check("brk_count", int'(fifo_count), 0);

        // 5: full FIFO, pop exactly on the push cycle of a fifth frame
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i), 1'b1, 8);
        end
        check("t5_full", int'(fifo_full), 1);
        exp_q.push_back(8'h14);
        fork
            send_frame(8'h14, 1'b1, 8);
            begin
                @(posedge clk);
                repeat (LAT - 1) @(posedge clk);
                #1 rd_en = 1'b1;
                @(posedge clk);
                #1 rd_en = 1'b0;
            end
        join
        check("t5_count", int'(fifo_count), 4);
        check("t5_overrun", int'(overrun), 0);
        read_words(4);
        check("t5_drained", int'(fifo_count), 0);

        // 6: reset mid-frame discards stored word and partial frame
        send_frame(8'h99, 1'b1, 8);
        check("t6_pre", int'(fifo_count), 1);
        send_frame(8'h77, 1'b1, 3);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("t6_rst_count", int'(fifo_count), 0);
        check("t6_rst_valid", int'(rx_valid), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 8);
        check("t6_count", int'(fifo_count), 1);
        read_words(1);

`ifdef UART_RX_PARITY_EN
        // 7: wrong parity -> parity_err pulse, word dropped
        pe0 = pe_pulses;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 8);
        par_flip = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t7_pe_pulse", pe_pulses - pe0, 1);
        check("t7_count", int'(fifo_count), 0);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
